// File: rtl/mt_pkg.sv
// Shared types and sizes for the register map table: one entry per
// architectural register holding its current physical tag and ready bit.
package mt_pkg;
  localparam int PR_W      = 7;
  localparam int AR_W      = 5;
  localparam int NUM_AR    = 32;
  localparam int NUM_CDB   = 4;
  localparam int CDB_WIDTH = 3;

  typedef struct packed {
    logic [PR_W-1:0] pr;
    logic            ready;
  } mt_entry_t;
endpackage

// File: rtl/mt_if.sv
// Rename bus between dispatch/ROB/CDB (master) and the map table (slave).
interface mt_if;
  import mt_pkg::*;

  logic [1:0]           rob_dispatch_num;
  logic [PR_W-1:0]      fl_pr0, fl_pr1;
  logic                 rob_ar_a_valid, rob_ar_b_valid;
  logic [AR_W-1:0]      rob_ar_a, rob_ar_b;
  logic                 rob_ar_a1_valid, rob_ar_a2_valid, rob_ar_b1_valid, rob_ar_b2_valid;
  logic [AR_W-1:0]      rob_ar_a1, rob_ar_a2, rob_ar_b1, rob_ar_b2;
  logic [CDB_WIDTH-1:0] cdb_broadcast;
  logic [PR_W-1:0]      cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3;
  logic [AR_W-1:0]      cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3;
  logic [PR_W-1:0]      rob_p0told, rob_p1told;
  logic [PR_W-1:0]      rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2;
  logic                 rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready;

  modport master (
    output rob_dispatch_num, fl_pr0, fl_pr1, rob_ar_a_valid, rob_ar_b_valid,
           rob_ar_a, rob_ar_b, rob_ar_a1_valid, rob_ar_a2_valid, rob_ar_b1_valid,
           rob_ar_b2_valid, rob_ar_a1, rob_ar_a2, rob_ar_b1, rob_ar_b2, cdb_broadcast,
           cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3,
           cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3,
    input  rob_p0told, rob_p1told, rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2,
           rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready
  );

  modport slave (
    input  rob_dispatch_num, fl_pr0, fl_pr1, rob_ar_a_valid, rob_ar_b_valid,
           rob_ar_a, rob_ar_b, rob_ar_a1_valid, rob_ar_a2_valid, rob_ar_b1_valid,
           rob_ar_b2_valid, rob_ar_a1, rob_ar_a2, rob_ar_b1, rob_ar_b2, cdb_broadcast,
           cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3,
           cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3,
    output rob_p0told, rob_p1told, rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2,
           rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready
  );
endinterface

// File: rtl/mt_entry.sv
// One map-table entry: resets to {IDX, ready}, takes dispatch writes, and is
// marked ready when a valid CDB slot names this AR with the current tag.
module mt_entry
  import mt_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [PR_W-1:0]      wr_pr,
  input  logic [NUM_CDB-1:0]   cdb_valid,
  input  logic [PR_W-1:0]      cdb_pr [NUM_CDB],
  input  logic [AR_W-1:0]      cdb_ar [NUM_CDB],
  output mt_entry_t            view
);
  mt_entry_t q;
  logic      cdb_hit;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    cdb_hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && cdb_ar[k] == AR_W'(IDX) && cdb_pr[k] == q.pr)
        cdb_hit = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments; the table lives in flops, not RAM,
  // because every entry must clear asynchronously to its identity mapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '{pr: PR_W'(IDX), ready: 1'b1};
    end else if (we) begin
      q <= '{pr: wr_pr, ready: 1'b0};
    end else if (cdb_hit) begin
      q.ready <= 1'b1;
    end
  end

  // Lookups see a completing tag in the same cycle it is broadcast.
  assign view = '{pr: q.pr, ready: q.ready | cdb_hit};
endmodule

// File: rtl/mt.sv
// Register map table: renames two destinations per cycle, looks up four
// sources with intra-pair forwarding, and tracks readiness from the CDB.
module mt
  import mt_pkg::*;
#(
  parameter int PR_W      = mt_pkg::PR_W,
  parameter int AR_W      = mt_pkg::AR_W,
  parameter int CDB_WIDTH = mt_pkg::CDB_WIDTH
) (
  input logic clock,
  input logic reset,
  mt_if.slave bus
);
  logic                 a_we, b_we;
  logic [NUM_CDB-1:0]   cdb_valid;
  logic [PR_W-1:0]      cdb_pr [NUM_CDB];
  logic [AR_W-1:0]      cdb_ar [NUM_CDB];
  mt_entry_t            view [NUM_AR];
  logic                 src_valid_unused;

  // Source-valid flags do not gate lookups; they are accepted but not used.
  assign src_valid_unused = &{bus.rob_ar_a1_valid, bus.rob_ar_a2_valid,
                              bus.rob_ar_b1_valid, bus.rob_ar_b2_valid};

  // A dispatch count of 3 behaves as 2, so bit 1 alone enables slot b.
  assign a_we = (bus.rob_dispatch_num != 2'd0) && bus.rob_ar_a_valid;
  assign b_we = bus.rob_dispatch_num[1] && bus.rob_ar_b_valid;

  assign cdb_pr[0] = bus.cdb_pr_tag0;
  assign cdb_pr[1] = bus.cdb_pr_tag1;
  assign cdb_pr[2] = bus.cdb_pr_tag2;
  assign cdb_pr[3] = bus.cdb_pr_tag3;
  assign cdb_ar[0] = bus.cdb_ar_tag0;
  assign cdb_ar[1] = bus.cdb_ar_tag1;
  assign cdb_ar[2] = bus.cdb_ar_tag2;
  assign cdb_ar[3] = bus.cdb_ar_tag3;

  // Counts above NUM_CDB simply validate every slot.
  for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
    assign cdb_valid[k] = bus.cdb_broadcast > CDB_WIDTH'(k);
  end

  for (genvar i = 0; i < NUM_AR; i++) begin : g_entry
    logic hit_a, hit_b;
    assign hit_a = a_we && bus.rob_ar_a == AR_W'(i);
    assign hit_b = b_we && bus.rob_ar_b == AR_W'(i);

    // Slot b is younger, so its tag wins when both slots name this AR.
    mt_entry #(.IDX(i)) u_entry (
      .clock     (clock),
      .reset     (reset),
      .we        (hit_a || hit_b),
      .wr_pr     (hit_b ? bus.fl_pr1 : bus.fl_pr0),
      .cdb_valid (cdb_valid),
      .cdb_pr    (cdb_pr),
      .cdb_ar    (cdb_ar),
      .view      (view[i])
    );
  end

  always_comb begin
    bus.rob_p0told     = view[bus.rob_ar_a].pr;
    bus.rs_pr_a1       = view[bus.rob_ar_a1].pr;
    bus.rs_pr_a1_ready = view[bus.rob_ar_a1].ready;
    bus.rs_pr_a2       = view[bus.rob_ar_a2].pr;
    bus.rs_pr_a2_ready = view[bus.rob_ar_a2].ready;

    // Slot b must observe slot a's rename within the same dispatch pair.
    bus.rob_p1told     = view[bus.rob_ar_b].pr;
    bus.rs_pr_b1       = view[bus.rob_ar_b1].pr;
    bus.rs_pr_b1_ready = view[bus.rob_ar_b1].ready;
    bus.rs_pr_b2       = view[bus.rob_ar_b2].pr;
    bus.rs_pr_b2_ready = view[bus.rob_ar_b2].ready;
    if (a_we && bus.rob_ar_b == bus.rob_ar_a) bus.rob_p1told = bus.fl_pr0;
    if (a_we && bus.rob_ar_b1 == bus.rob_ar_a) begin
      bus.rs_pr_b1       = bus.fl_pr0;
      bus.rs_pr_b1_ready = 1'b0;
    end
    if (a_we && bus.rob_ar_b2 == bus.rob_ar_a) begin
      bus.rs_pr_b2       = bus.fl_pr0;
      bus.rs_pr_b2_ready = 1'b0;
    end
  end
endmodule

// File: tb/tb_mt.sv
// Scoreboard bench for the map table: directed rename/CDB/reset scenarios
// with hand-derived expectations, then random traffic against a reference model.
module tb_mt;
  typedef struct packed {
    logic [1:0]      num;
    logic [6:0]      fl0, fl1;
    logic            av, bv;
    logic [4:0]      ar_a, ar_b;
    logic [3:0][4:0] src;   // [0]=a1 [1]=a2 [2]=b1 [3]=b2
    logic [2:0]      cnt;
    logic [3:0][6:0] cpr;
    logic [3:0][4:0] car;
  } stim_t;

  typedef struct packed {
    logic [6:0]      t0, t1;
    logic [3:0][6:0] pr;
    logic [3:0]      rdy;   // bit j matches src[j]
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb [$];

  logic [6:0] m_pr  [32];
  logic       m_rdy [32];

  mt_if bus ();
  mt u_dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic exp_t mk_exp(input logic [6:0] t0, t1, p0, p1, p2, p3, input logic [3:0] rdy);
    exp_t e;
    e.t0 = t0; e.t1 = t1;
    e.pr[0] = p0; e.pr[1] = p1; e.pr[2] = p2; e.pr[3] = p3;
    e.rdy = rdy;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_pr[i]  = 7'(i);
      m_rdy[i] = 1'b1;
    end
  endtask

  function automatic exp_t model_expect(input stim_t s);
    exp_t       e;
    logic       a_we;
    logic [4:0] ar;
    a_we = (s.num != 2'd0) && s.av;
    e.t0 = m_pr[s.ar_a];
    e.t1 = (a_we && s.ar_b == s.ar_a) ? s.fl0 : m_pr[s.ar_b];
    for (int j = 0; j < 4; j++) begin
      ar = s.src[j];
      if (j >= 2 && a_we && ar == s.ar_a) begin
        e.pr[j]  = s.fl0;
        e.rdy[j] = 1'b0;
      end else begin
        e.pr[j]  = m_pr[ar];
        e.rdy[j] = m_rdy[ar];
        for (int k = 0; k < 4; k++)
          if (k < int'(s.cnt) && s.car[k] == ar && s.cpr[k] == m_pr[ar]) e.rdy[j] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_step(input stim_t s);
    for (int k = 0; k < 4; k++)
      if (k < int'(s.cnt) && m_pr[s.car[k]] == s.cpr[k]) m_rdy[s.car[k]] = 1'b1;
    if (s.num != 2'd0 && s.av) begin
      m_pr[s.ar_a] = s.fl0; m_rdy[s.ar_a] = 1'b0;
    end
    if (s.num[1] && s.bv) begin
      m_pr[s.ar_b] = s.fl1; m_rdy[s.ar_b] = 1'b0;
    end
  endtask

  task automatic drive(input stim_t s);
    bus.rob_dispatch_num = s.num;
    bus.fl_pr0 = s.fl0;        bus.fl_pr1 = s.fl1;
    bus.rob_ar_a_valid = s.av; bus.rob_ar_b_valid = s.bv;
    bus.rob_ar_a = s.ar_a;     bus.rob_ar_b = s.ar_b;
    bus.rob_ar_a1_valid = 1'b1; bus.rob_ar_a2_valid = 1'b1;
    bus.rob_ar_b1_valid = 1'b1; bus.rob_ar_b2_valid = 1'b1;
    bus.rob_ar_a1 = s.src[0]; bus.rob_ar_a2 = s.src[1];
    bus.rob_ar_b1 = s.src[2]; bus.rob_ar_b2 = s.src[3];
    bus.cdb_broadcast = s.cnt;
    bus.cdb_pr_tag0 = s.cpr[0]; bus.cdb_pr_tag1 = s.cpr[1];
    bus.cdb_pr_tag2 = s.cpr[2]; bus.cdb_pr_tag3 = s.cpr[3];
    bus.cdb_ar_tag0 = s.car[0]; bus.cdb_ar_tag1 = s.car[1];
    bus.cdb_ar_tag2 = s.car[2]; bus.cdb_ar_tag3 = s.car[3];
  endtask

  // Pops the oldest expectation and compares it with what the DUT drives now.
  task automatic compare(input string name);
    exp_t            e;
    logic [3:0][6:0] got_pr;
    logic [3:0]      got_rdy;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    n_pass++;
    e = sb.pop_front();
    got_pr  = {bus.rs_pr_b2, bus.rs_pr_b1, bus.rs_pr_a2, bus.rs_pr_a1};
    got_rdy = {bus.rs_pr_b2_ready, bus.rs_pr_b1_ready, bus.rs_pr_a2_ready, bus.rs_pr_a1_ready};
    n_checks++;
    if (bus.rob_p0told !== e.t0) $display("FAIL %s p0told got %0d expected %0d", name, bus.rob_p0told, e.t0);
    else n_pass++;
    n_checks++;
    if (bus.rob_p1told !== e.t1) $display("FAIL %s p1told got %0d expected %0d", name, bus.rob_p1told, e.t1);
    else n_pass++;
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (got_pr[j] !== e.pr[j]) $display("FAIL %s src%0d pr got %0d expected %0d", name, j, got_pr[j], e.pr[j]);
      else n_pass++;
    end
    n_checks++;
    if (got_rdy !== e.rdy) $display("FAIL %s ready got %b expected %b", name, got_rdy, e.rdy);
    else n_pass++;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 later.
  task automatic cycle(input stim_t s, input string name);
    drive(s);
    #2;
    compare(name);
    model_step(s);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    s = idle();
    s.ar_a = 5'd0; s.ar_b = 5'd31;
    s.src[0] = 5'd5; s.src[1] = 5'd6; s.src[2] = 5'd30; s.src[3] = 5'd31;
    drive(s);
    model_reset();
    repeat (2) @(posedge clock);
    #3;
    sb.push_back(mk_exp(0, 31, 5, 6, 30, 31, 4'b1111));
    compare("reset_held");
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    sb.push_back(mk_exp(0, 31, 5, 6, 30, 31, 4'b1111));
    cycle(s, "reset_released");
  endtask

  task automatic test_dispatch();
    stim_t s;
    s = idle();
    s.num = 2'd2; s.av = 1'b1; s.bv = 1'b1;
    s.ar_a = 5'd3; s.fl0 = 7'd32; s.ar_b = 5'd4; s.fl1 = 7'd33;
    s.src[0] = 5'd5; s.src[1] = 5'd6; s.src[2] = 5'd7; s.src[3] = 5'd8;
    sb.push_back(mk_exp(3, 4, 5, 6, 7, 8, 4'b1111));
    cycle(s, "dispatch_pair");
  endtask

  task automatic test_read_back();
    stim_t s;
    s = idle();
    s.ar_a = 5'd3; s.ar_b = 5'd4;
    s.src[0] = 5'd3; s.src[1] = 5'd4; s.src[2] = 5'd3; s.src[3] = 5'd4;
    sb.push_back(mk_exp(32, 33, 32, 33, 32, 33, 4'b0000));
    cycle(s, "read_renamed");
  endtask

  // Only slot 0 is valid, so slot 1's tag for r3 must not mark anything.
  task automatic test_cdb_bypass();
    stim_t s;
    s = idle();
    s.ar_a = 5'd4; s.ar_b = 5'd3;
    s.src[0] = 5'd4; s.src[1] = 5'd3; s.src[2] = 5'd4; s.src[3] = 5'd3;
    s.cnt = 3'd1;
    s.cpr[0] = 7'd33; s.car[0] = 5'd4;
    s.cpr[1] = 7'd32; s.car[1] = 5'd3;
    sb.push_back(mk_exp(33, 32, 33, 32, 33, 32, 4'b0101));
    cycle(s, "cdb_bypass");
  endtask

  task automatic test_cdb_update();
    stim_t s;
    s = idle();
    s.ar_a = 5'd3; s.ar_b = 5'd4;
    s.src[0] = 5'd0; s.src[1] = 5'd1; s.src[2] = 5'd2; s.src[3] = 5'd9;
    s.cnt = 3'd2;
    s.cpr[0] = 7'd32; s.car[0] = 5'd3;
    s.cpr[1] = 7'd33; s.car[1] = 5'd4;
    sb.push_back(mk_exp(32, 33, 0, 1, 2, 9, 4'b1111));
    cycle(s, "cdb_update");
    s = idle();
    s.ar_a = 5'd3; s.ar_b = 5'd4;
    s.src[0] = 5'd3; s.src[1] = 5'd4; s.src[2] = 5'd3; s.src[3] = 5'd4;
    sb.push_back(mk_exp(32, 33, 32, 33, 32, 33, 4'b1111));
    cycle(s, "cdb_readback");
  endtask

  task automatic test_same_dest();
    stim_t s;
    s = idle();
    s.num = 2'd2; s.av = 1'b1; s.bv = 1'b1;
    s.ar_a = 5'd20; s.fl0 = 7'd41; s.ar_b = 5'd20; s.fl1 = 7'd42;
    s.src[0] = 5'd20; s.src[1] = 5'd1; s.src[2] = 5'd20; s.src[3] = 5'd2;
    sb.push_back(mk_exp(20, 41, 20, 1, 41, 2, 4'b1011));
    cycle(s, "same_dest");
    s = idle();
    s.ar_a = 5'd20; s.ar_b = 5'd20;
    s.src[0] = 5'd20; s.src[1] = 5'd20; s.src[2] = 5'd20; s.src[3] = 5'd20;
    sb.push_back(mk_exp(42, 42, 42, 42, 42, 42, 4'b0000));
    cycle(s, "same_dest_next");
  endtask

  // Single dispatch with b_valid set: slot b must not write.
  task automatic test_stale_cdb();
    stim_t s;
    s = idle();
    s.num = 2'd1; s.av = 1'b1; s.bv = 1'b1;
    s.ar_a = 5'd3; s.fl0 = 7'd50; s.ar_b = 5'd5; s.fl1 = 7'd60;
    s.src[0] = 5'd3; s.src[1] = 5'd4; s.src[2] = 5'd3; s.src[3] = 5'd5;
    sb.push_back(mk_exp(32, 5, 32, 33, 50, 5, 4'b1011));
    cycle(s, "remap_r3");
    s = idle();
    s.ar_a = 5'd3; s.ar_b = 5'd20;
    s.src[0] = 5'd3; s.src[1] = 5'd20; s.src[2] = 5'd4; s.src[3] = 5'd5;
    s.cnt = 3'd1; s.cpr[0] = 7'd32; s.car[0] = 5'd3;
    sb.push_back(mk_exp(50, 42, 50, 42, 33, 5, 4'b1100));
    cycle(s, "stale_cdb");
    s = idle();
    s.ar_a = 5'd3; s.ar_b = 5'd5;
    s.src[0] = 5'd3; s.src[1] = 5'd3; s.src[2] = 5'd3; s.src[3] = 5'd3;
    sb.push_back(mk_exp(50, 5, 50, 50, 50, 50, 4'b0000));
    cycle(s, "stale_readback");
  endtask

  task automatic test_reset_mid();
    stim_t s;
    s = idle();
    s.ar_a = 5'd3; s.ar_b = 5'd20;
    s.src[0] = 5'd20; s.src[1] = 5'd3; s.src[2] = 5'd31; s.src[3] = 5'd0;
    drive(s);
    reset = 1'b0;
    #1;
    sb.push_back(mk_exp(3, 20, 20, 3, 31, 0, 4'b1111));
    compare("reset_mid");
    model_reset();
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    stim_t s;
    for (int n = 0; n < 60; n++) begin
      s = idle();
      s.num  = 2'($urandom_range(0, 3));
      s.av   = 1'($urandom_range(0, 1));
      s.bv   = 1'($urandom_range(0, 1));
      s.fl0  = 7'($urandom_range(0, 127));
      s.fl1  = 7'($urandom_range(0, 127));
      s.ar_a = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      s.ar_b = 5'($urandom_range(0, 7));
      for (int j = 0; j < 4; j++) s.src[j] = 5'($urandom_range(0, 7));
      s.cnt = 3'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) begin
        s.car[k] = 5'($urandom_range(0, 7));
        s.cpr[k] = ($urandom_range(0, 3) != 0) ? m_pr[s.car[k]] : 7'($urandom_range(0, 127));
      end
      sb.push_back(model_expect(s));
      cycle(s, "random");
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_read_back();
    test_cdb_bypass();
    test_cdb_update();
    test_same_dest();
    test_stale_cdb();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mt.md
MT -- requirements
Module: mt

Interface
REQ-001 Parameter PR_W, default 7, physical-register tag width (128 PRs).
REQ-002 Parameter AR_W, default 5, architectural-register index width (32 ARs).
REQ-003 Parameter CDB_WIDTH, default 3, width of the CDB valid-count field.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; asserted while low.
REQ-006 rob_dispatch_num  in  2  instructions dispatched this cycle (0, 1 or 2; 3 treated as 2); slot a = older, slot b = younger.
REQ-007 fl_pr0 / fl_pr1  in  7 each  free-list PRs for the destinations of slots a / b.
REQ-008 rob_ar_a_valid / rob_ar_b_valid  in  1 each  slot a / b has a destination register.
REQ-009 rob_ar_a / rob_ar_b  in  5 each  destination AR of slots a / b.
REQ-010 rob_ar_a1_valid, rob_ar_a2_valid, rob_ar_b1_valid, rob_ar_b2_valid  in  1 each  source operand present (informational; lookups are always performed).
REQ-011 rob_ar_a1, rob_ar_a2, rob_ar_b1, rob_ar_b2  in  5 each  source ARs of slots a / b.
REQ-012 cdb_broadcast  in  CDB_WIDTH  count of valid CDB slots; slots 0..count-1 valid, count > 4 treated as 4.
REQ-013 cdb_pr_tag0..3  in  7 each  completing PR per CDB slot.
REQ-014 cdb_ar_tag0..3  in  5 each  AR of the completing PR per CDB slot.
REQ-015 rob_p0told / rob_p1told  out  7 each  previous mapping of rob_ar_a / rob_ar_b.
REQ-016 rs_pr_a1, rs_pr_a2, rs_pr_b1, rs_pr_b2  out  7 each  renamed source PRs.
REQ-017 rs_pr_a1_ready, rs_pr_a2_ready, rs_pr_b1_ready, rs_pr_b2_ready  out  1 each  source value available.

Function
REQ-018 State: 32 entries, each {pr[6:0], ready}.
REQ-019 All outputs are combinational from current state and current inputs (zero latency); updates are visible from the next cycle.
REQ-020 rob_p0told = entry[rob_ar_a].pr; rs_pr_a1/a2 and ready = entry lookup of rob_ar_a1/a2.
REQ-021 Slot b sees slot a's rename: if slot a writes (dispatch_num>=1, a_valid) and rob_ar_b == rob_ar_a, rob_p1told = fl_pr0.
REQ-022 Slot b source forwarding: if slot a writes and rob_ar_b1 (or b2) == rob_ar_a, rs_pr_b1 (or b2) = fl_pr0 with ready = 0.
REQ-023 Same-cycle CDB bypass: a looked-up source whose entry.pr equals a valid cdb_pr_tag with matching cdb_ar_tag reports ready = 1; this does not apply to sources forwarded under REQ-022.
REQ-024 CDB update: for each valid slot k, if entry[cdb_ar_tagk].pr == cdb_pr_tagk, that entry's ready is set to 1; stale tags are ignored.
REQ-025 Dispatch update: slot a writes entry[rob_ar_a] = {fl_pr0, 0} when dispatch_num>=1 and a_valid; slot b writes entry[rob_ar_b] = {fl_pr1, 0} when dispatch_num==2 and b_valid.
REQ-026 Priority on the same entry in one cycle: slot b write > slot a write > CDB ready-set.
REQ-027 dispatch_num = 0 or invalid destinations leave the table unchanged apart from CDB updates.
REQ-028 AR 0 and AR 31 receive no special treatment.

Reset
REQ-029 While reset is low, entry i = {pr = i, ready = 1} for all i; the table is cleared asynchronously, including mid-operation.
REQ-030 Resulting outputs after reset: told = AR index, rs_pr_* = source AR index, all ready = 1.

Structure
REQ-031 Shared package holds PR_W, AR_W, NUM_AR=32, NUM_CDB=4, CDB_WIDTH, and an entry struct {pr, ready}.
REQ-032 Optional sub-module mt_entry: one register entry with async reset, write-enable, and CDB-match ready-set; mt instantiates 32 of these plus lookup/forwarding logic.

Verification
REQ-033 After reset, dispatch 2 with a=r3 (p32), b=r4 (p33), sources r5..r8 -> told 3 and 4; sources 5, 6, 7, 8 all ready.
REQ-034 Next cycle, read r3/r4 -> 32 and 33, not ready; then CDB count 2 with {p32,r3} and {p33,r4} -> following cycle r3/r4 = 32/33, ready.
REQ-035 Same-dest pair: a=b=r20, fl 41/42, b1=r20 -> p0told=20, p1told=41, rs_pr_b1=41 not ready; next cycle r20 = 42.
REQ-036 Stale CDB: {p32,r3} after r3 remapped to p50 -> r3 stays p50, not ready.
REQ-037 Same-cycle CDB and source lookup of p33/r4 -> ready = 1 combinationally.
REQ-038 Reset asserted mid-sequence -> all entries are identity and ready immediately, without waiting for a clock edge.
